// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 scancode-set-2 key tracker.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Keyboard status/response bytes that never start a key sequence.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == PS2_FAKE_LSHIFT) || (b == PS2_FAKE_RSHIFT);
  endfunction

  function automatic ps2_event_t make_event(input logic ext, input logic brk,
                                            input logic [7:0] code);
    ps2_event_t ev;
    ev.ext  = ext;
    ev.brk  = brk;
    ev.code = code;
    return ev;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO with wrap-bit pointers and a sticky overflow flag.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  ps2_event_t push_ev,
  input  logic       pop_ready,
  output ps2_event_t head_ev,
  output logic       valid,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  ps2_event_t  mem [DEPTH];
  logic        empty, full, do_pop, do_push, drop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop  = !empty && pop_ready;
    do_push = push && (!full || do_pop);
    drop    = push && full && !do_pop;
    valid   = !empty;
    head_ev = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_ev;
  end

  // A fresh drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Prefix-aware PS/2 set-2 decoder: held-key bitmap, press pulses, event FIFO.
// Define TYPEMATIC_FILTER_EN to keep typematic repeats of held table keys out of the FIFO.
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS    = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_TABLE   = {9'h16B, 9'h05A, 9'h01B, 9'h01C},
  parameter int                    FIFO_DEPTH  = 8,
  parameter int                    TIMEOUT_CYC = 500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_done_tick,
  input  logic [7:0]          rx_data,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [7:0]          ev_code,
  output logic                ev_ext,
  output logic                ev_break,
  output logic                overflow,
  input  logic                clr_overflow
);

  localparam int             TW       = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);

  ps2_state_t          state, state_nx;
  logic [2:0]          skip_cnt, skip_nx;
  logic [TW-1:0]       tmo_cnt;
  logic                emit, push;
  ps2_event_t          emit_ev, head_ev;
  logic [NUM_KEYS-1:0] make_hit, brk_hit;

  always_comb begin
    state_nx = state;
    skip_nx  = skip_cnt;
    emit     = 1'b0;
    emit_ev  = '0;
    if (rx_done_tick) begin
      case (state)
        IDLE: begin
          if (rx_data == PS2_EXT) state_nx = EXT;
          else if (rx_data == PS2_BRK) state_nx = BRK;
          else if (rx_data == PS2_PAUSE) begin
            state_nx = SKIP;
            skip_nx  = 3'd7;
          end else if (!is_ignored(rx_data)) begin
            emit    = 1'b1;
            emit_ev = make_event(1'b0, 1'b0, rx_data);
          end
        end
        EXT: begin
          if (rx_data == PS2_BRK) state_nx = EXT_BRK;
          else begin
            state_nx = IDLE;
            emit     = !is_fake_shift(rx_data);
            emit_ev  = make_event(1'b1, 1'b0, rx_data);
          end
        end
        BRK: begin
          state_nx = IDLE;
          emit     = 1'b1;
          emit_ev  = make_event(1'b0, 1'b1, rx_data);
        end
        EXT_BRK: begin
          state_nx = IDLE;
          emit     = !is_fake_shift(rx_data);
          emit_ev  = make_event(1'b1, 1'b1, rx_data);
        end
        SKIP: begin
          skip_nx = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
      state_nx = IDLE;
    end
  end

  // Match the emitted event against the key table; a break clears, a make sets.
  always_comb begin
    make_hit = '0;
    brk_hit  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (emit && ({emit_ev.ext, emit_ev.code} == KEY_TABLE[i*9 +: 9])) begin
        make_hit[i] = !emit_ev.brk;
        brk_hit[i]  = emit_ev.brk;
      end
    end
`ifdef TYPEMATIC_FILTER_EN
    push = emit && !(|(make_hit & key_held));
`else
    push = emit;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      tmo_cnt   <= '0;
      key_held  <= '0;
      key_press <= '0;
    end else begin
      state     <= state_nx;
      skip_cnt  <= skip_nx;
      tmo_cnt   <= (rx_done_tick || state_nx == IDLE) ? '0 : tmo_cnt + TW'(1);
      key_held  <= (key_held | make_hit) & ~brk_hit;
      key_press <= make_hit & ~key_held;
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_ev     (emit_ev),
    .pop_ready   (ev_ready),
    .head_ev     (head_ev),
    .valid       (ev_valid),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  assign ev_code  = head_ev.code;
  assign ev_ext   = head_ev.ext;
  assign ev_break = head_ev.brk;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed self-checking bench for ps2_key_tracker (short timeout for simulation).
module tb_ps2_key_tracker;

  localparam int NUM_KEYS    = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int TIMEOUT_CYC = 40;
`ifdef TYPEMATIC_FILTER_EN
  localparam int TYPEMATIC_EVENTS = 1;
`else
  localparam int TYPEMATIC_EVENTS = 3;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                rx_done_tick;
  logic [7:0]          rx_data;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_press;
  logic                ev_valid;
  logic                ev_ready;
  logic [7:0]          ev_code;
  logic                ev_ext;
  logic                ev_break;
  logic                overflow;
  logic                clr_overflow;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ps2_key_tracker #(
    .NUM_KEYS   (NUM_KEYS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .key_held    (key_held),
    .key_press   (key_press),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_code     (ev_code),
    .ev_ext      (ev_ext),
    .ev_break    (ev_break),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle byte strobe; returns at the negedge after the sampling edge.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic popEvent(input string tag, input logic [9:0] exp_ev);
    checkOutput({tag, "_valid"}, 32'(ev_valid), 32'd1);
    checkOutput(tag, {22'd0, ev_ext, ev_break, ev_code}, 32'(exp_ev));
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    ev_ready     = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_held",  32'(key_held),  32'd0);
    checkOutput("rst_press", 32'(key_press), 32'd0);
    checkOutput("rst_valid", 32'(ev_valid),  32'd0);
    checkOutput("rst_ovf",   32'(overflow),  32'd0);
    checkOutput("rst_code",  32'(ev_code),   32'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] make/break of A");
    applyStimulus(8'h1C);
    checkOutput("a_held",   32'(key_held),  32'h1);
    checkOutput("a_press",  32'(key_press), 32'h1);
    @(negedge clk);
    checkOutput("a_press_once", 32'(key_press), 32'h0);
    popEvent("a_make", {2'b00, 8'h1C});
    applyStimulus(8'hF0);
    checkOutput("a_held_mid", 32'(key_held), 32'h1);
    applyStimulus(8'h1C);
    checkOutput("a_released", 32'(key_held), 32'h0);
    popEvent("a_break", {2'b01, 8'h1C});
    checkOutput("a_empty", 32'(ev_valid), 32'd0);

    $display("[TB] extended left arrow with A held");
    applyStimulus(8'h1C);
    applyStimulus(8'hE0);
    applyStimulus(8'h6B);
    checkOutput("left_held",  32'(key_held),  32'h9);
    checkOutput("left_press", 32'(key_press), 32'h8);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h6B);
    checkOutput("left_released", 32'(key_held), 32'h1);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    checkOutput("all_released", 32'(key_held), 32'h0);
    popEvent("ext_a_make",  {2'b00, 8'h1C});
    popEvent("left_make",   {2'b10, 8'h6B});
    popEvent("left_break",  {2'b11, 8'h6B});
    popEvent("ext_a_break", {2'b01, 8'h1C});

    $display("[TB] typematic repeat");
    applyStimulus(8'h1C);
    checkOutput("typ_press1", 32'(key_press), 32'h1);
    applyStimulus(8'h1C);
    checkOutput("typ_press2", 32'(key_press), 32'h0);
    applyStimulus(8'h1C);
    checkOutput("typ_press3", 32'(key_press), 32'h0);
    checkOutput("typ_held",   32'(key_held),  32'h1);
    for (int i = 0; i < TYPEMATIC_EVENTS; i++) popEvent("typ_make", {2'b00, 8'h1C});
    checkOutput("typ_count", 32'(ev_valid), 32'd0);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    popEvent("typ_break", {2'b01, 8'h1C});

    $display("[TB] pause sequence then Enter");
    applyStimulus(8'hE1);
    applyStimulus(8'h14);
    applyStimulus(8'h77);
    applyStimulus(8'hE1);
    applyStimulus(8'hF0);
    applyStimulus(8'h14);
    applyStimulus(8'hF0);
    applyStimulus(8'h77);
    checkOutput("pause_no_ev",   32'(ev_valid), 32'd0);
    checkOutput("pause_no_held", 32'(key_held), 32'h0);
    applyStimulus(8'h5A);
    checkOutput("enter_held", 32'(key_held), 32'h4);
    popEvent("enter_make", {2'b00, 8'h5A});
    checkOutput("enter_only", 32'(ev_valid), 32'd0);
    applyStimulus(8'hF0);
    applyStimulus(8'h5A);
    popEvent("enter_break", {2'b01, 8'h5A});

    $display("[TB] prefix timeout");
    applyStimulus(8'hE0);
    repeat (TIMEOUT_CYC - 3) @(negedge clk);
    applyStimulus(8'h6B);
    checkOutput("tmo_late_ext", 32'(key_held), 32'h8);
    popEvent("tmo_late_make", {2'b10, 8'h6B});
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h6B);
    popEvent("tmo_late_break", {2'b11, 8'h6B});
    applyStimulus(8'hE0);
    repeat (TIMEOUT_CYC) @(negedge clk);
    applyStimulus(8'h1B);
    checkOutput("tmo_s_held", 32'(key_held), 32'h2);
    popEvent("tmo_s_make", {2'b00, 8'h1B});
    applyStimulus(8'hF0);
    applyStimulus(8'h1B);
    popEvent("tmo_s_break", {2'b01, 8'h1B});

    $display("[TB] overflow and full-FIFO behaviour");
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h21 + i));
    checkOutput("ovf_not_yet", 32'(overflow), 32'd0);
    applyStimulus(8'h29);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) popEvent("ovf_pop", {2'b00, 8'(8'h21 + i)});
    checkOutput("ovf_dropped", 32'(ev_valid), 32'd0);
    checkOutput("ovf_sticky",  32'(overflow), 32'd1);
    @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    checkOutput("ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h31 + i));
    @(negedge clk);
    rx_data      = 8'h3A;
    rx_done_tick = 1'b1;
    clr_overflow = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    clr_overflow = 1'b0;
    checkOutput("ovf_wins_clr", 32'(overflow), 32'd1);
    @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    @(negedge clk);
    rx_data      = 8'h39;
    rx_done_tick = 1'b1;
    ev_ready     = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    ev_ready     = 1'b0;
    checkOutput("full_pushpop_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 9; i++) popEvent("full_pushpop", {2'b00, 8'(8'h31 + i)});
    checkOutput("full_drained", 32'(ev_valid), 32'd0);

    $display("[TB] reset mid-sequence");
    applyStimulus(8'h1C);
    applyStimulus(8'hE0);
    checkOutput("mid_held",  32'(key_held), 32'h1);
    checkOutput("mid_valid", 32'(ev_valid), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_held",  32'(key_held), 32'h0);
    checkOutput("mid_rst_valid", 32'(ev_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(8'h6B);
    checkOutput("post_rst_held", 32'(key_held), 32'h0);
    popEvent("post_rst_plain", {2'b00, 8'h6B});
    checkOutput("post_rst_empty", 32'(ev_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised PS/2 scancode-set-2 decoder that sits between ps2_rx and game logic. It replaces the single-key, one-byte-lag decoder with a prefix-aware state machine that handles E0 (extended), F0 (break) and E1 (pause) sequences. It provides a held-key bitmap and a one-cycle press pulse for a configurable key table, plus a buffered make/break event stream for menu and text input.

Parameters:
NUM_KEYS, 4, number of tracked keys (1..16)
KEY_TABLE, {9'h16B, 9'h05A, 9'h01B, 9'h01C}, NUM_KEYS x 9-bit entries {ext, code}; index 0 = LSB entry (0:'A' 1C, 1:'S' 1B, 2:Enter 5A, 3:Left-arrow E0 6B)
FIFO_DEPTH, 8, event FIFO depth; power of 2, at least 2
TIMEOUT_CYC, 500000, idle clocks after a prefix byte before the sequence is abandoned (5 ms at 100 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_done_tick  in  1  one-cycle strobe from ps2_rx; byte valid
rx_data  in  8  received byte (ps2_rx dout)
key_held  out  NUM_KEYS  1 while the table key is down
key_press  out  NUM_KEYS  one-cycle pulse on the 0->1 transition of key_held
ev_valid  out  1  event FIFO not empty
ev_ready  in  1  consumer pop; pops when ev_valid && ev_ready
ev_code  out  8  head event scancode
ev_ext  out  1  head event had E0 prefix
ev_break  out  1  head event is a release
overflow  out  1  sticky; an event was dropped because the FIFO was full
clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, all outputs 0, FIFO empty, timeout counter 0.
- FSM consumes bytes only on rx_done_tick.
  - IDLE: E0->EXT, F0->BRK, E1->SKIP (skip_cnt=7). AA, FA, EE, FE, 00 and FF are ignored. Any other byte emits a make {ext=0}.
  - EXT: F0->EXT_BRK, 12 or 59 (fake shift) -> IDLE with no event, else emit make {ext=1} -> IDLE.
  - BRK: emit break {ext=0} -> IDLE.
  - EXT_BRK: 12 or 59 -> IDLE with no event, else emit break {ext=1} -> IDLE.
  - SKIP: decrement skip_cnt; go to IDLE when it reaches 0. No events are emitted.
- Timeout: in any state other than IDLE, the counter increments each clk without rx_done_tick and clears on rx_done_tick. When it reaches TIMEOUT_CYC-1, the FSM returns to IDLE with no event. The counter is held at 0 in IDLE.
- Emit (registered, 1-cycle latency from the code-byte tick):
  - Table match on {ext, code}: make sets key_held[i], break clears it. key_press[i]=1 for exactly one cycle only if key_held[i] was 0.
  - A break for a key that is not held is harmless.
  - Every emitted event is pushed to the FIFO (subject to the optional feature).
- FIFO:
  - Outputs show the head combinationally from registered storage. ev_valid rises the cycle after the first push.
  - Push when full without a simultaneous pop: the event is dropped and overflow is set.
  - Push and pop in the same cycle when full: both succeed.
  - Pointers use log2(FIFO_DEPTH)+1 bits and wrap naturally.
- clr_overflow and a new overflow in the same cycle: overflow stays 1.

Optional Feature:
TYPEMATIC_FILTER_EN
- Defined: a make for a table key whose key_held bit is already 1 (typematic repeat) is not pushed to the FIFO.
- Not defined: every make, including repeats, is pushed.
- key_held and key_press behave identically in both builds.

Decomposition:
- Package ps2_pkg holds:
  - FSM state enum (IDLE, EXT, BRK, EXT_BRK, SKIP).
  - Byte constants PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PS2_ACK=FA, PS2_ECHO=EE, PS2_RESEND=FE.
  - Event struct {ext, brk, code[7:0]}.
- One sub-module, ps2_event_fifo: a synchronous FIFO with the full/empty/overflow rules above.
- The scancode FSM, timeout counter and key table stay in ps2_key_tracker.

Test Plan:
- Send 1C, then F0 1C -> key_held[0] is 1 the cycle after the first tick and key_press[0] pulses once. After 1C: FIFO {0,0,1C}. After F0 1C: key_held[0]=0 and FIFO {0,1,1C}.
- Send E0 6B, then E0 F0 6B -> key_held[3] sets then clears. FIFO events are {1,0,6B} and {1,1,6B}. key_held[0] is unaffected.
- Send 1C three times (typematic) -> one key_press[0] pulse. The FIFO holds 3 events without TYPEMATIC_FILTER_EN and 1 event with it.
- Send E1 14 77 E1 F0 14 F0 77, then 5A -> no events during the pause sequence. key_held[2]=1 and the FIFO holds only {0,0,5A}.
- Send E0 then no byte for TIMEOUT_CYC clocks, then 1B -> the FSM returns to IDLE and the event is {0,0,1B} (not extended).
- With ev_ready=0, push 9 events into depth 8 -> overflow=1 and the 9th event is dropped. Pop all 8 in order. Then: simultaneous push/pop when full succeeds; reset asserted mid-sequence clears the FSM, the FIFO and key_held.
